// File: rtl/mux2x1_monitor.sv
// -----------------------------------------------------------------------------
// mux2x1_monitor
//
// Passive protocol checker and functional-coverage collector for a registered
// 2:1 multiplexer. It taps the mux pins and predicts y one cycle ahead. It
// flags and counts mismatches, and records which {sel,i1,i0} combinations
// and which y transitions have been seen.
//
// Parameters
//   CNT_W        width of every counter (error, sample, per-bin)
//
// Ports
//   clk          clock shared with the mux
//   rst          asynchronous active-high reset, same net as the mux reset
//   i0, i1, sel  observed mux inputs (sel=0 selects i0, sel=1 selects i1)
//   y            observed registered mux output
//   err          sticky mismatch flag
//   err_pulse    one-cycle pulse after each mismatching edge
//   err_count    saturating mismatch count
//   sample_count saturating count of edges sampled with rst low
//   bin_hit      bit n set once {sel,i1,i0} == n has been sampled
//   bin_count    per-bin saturating counts, bin n at [n*CNT_W +: CNT_W]
//   y_rise_hit   a 0->1 transition of y has been observed
//   y_fall_hit   a 1->0 transition of y has been observed
//   cov_complete all bins hit and both y transitions seen (combinational)
// -----------------------------------------------------------------------------
module mux2x1_monitor #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i0,
    input  logic               i1,
    input  logic               sel,
    input  logic               y,
    output logic               err,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   sample_count,
    output logic [7:0]         bin_hit,
    output logic [8*CNT_W-1:0] bin_count,
    output logic               y_rise_hit,
    output logic               y_fall_hit,
    output logic               cov_complete
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic       exp_y;
    logic       y_prev;
    logic       mux_now;
    logic       mismatch;
    logic [2:0] bin_idx;

    assign mux_now  = sel ? i1 : i0;
    // exp_y holds what the mux should have registered at the previous edge;
    // after reset it is 0, which also covers the reset-value check.
    assign mismatch = (y != exp_y);
    assign bin_idx  = {sel, i1, i0};

    // Prediction and transition history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_y  <= 1'b0;
            y_prev <= 1'b0;
        end else begin
            exp_y  <= mux_now;
            y_prev <= y;
        end
    end

    // Mismatch reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= mismatch;
            if (mismatch) begin
                err       <= 1'b1;
                err_count <= sat_inc(err_count);
            end
        end
    end

    // Sample counter and y transition coverage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count <= '0;
            y_rise_hit   <= 1'b0;
            y_fall_hit   <= 1'b0;
        end else begin
            sample_count <= sat_inc(sample_count);
            if (!y_prev && y) begin
                y_rise_hit <= 1'b1;
            end
            if (y_prev && !y) begin
                y_fall_hit <= 1'b1;
            end
        end
    end

    // Per-combination coverage bins
    for (genvar n = 0; n < 8; n++) begin : g_bin
        logic             hit_q;
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hit_q <= 1'b0;
                cnt_q <= '0;
            end else if (bin_idx == 3'(n)) begin
                hit_q <= 1'b1;
                cnt_q <= sat_inc(cnt_q);
            end
        end

        assign bin_hit[n]                   = hit_q;
        assign bin_count[n*CNT_W +: CNT_W]  = cnt_q;
    end

    assign cov_complete = (&bin_hit) & y_rise_hit & y_fall_hit;

endmodule

// File: tb/tb_mux2x1_monitor.sv
// -----------------------------------------------------------------------------
// tb_mux2x1_monitor
//
// Bench for mux2x1_monitor. The bench plays the registered mux itself,
// driving y from its own model (optionally inverted to plant a fault), and
// keeps a reference of the monitor's counters. Each applied vector pushes
// its expected monitor state onto a queue that is popped and compared after
// the edge. A second instance with CNT_W=2 shares the same pins and checks
// counter saturation.
// -----------------------------------------------------------------------------
module tb_mux2x1_monitor;

    localparam int W  = 16;
    localparam int WS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i0 = 1'b0, i1 = 1'b0, sel = 1'b0, y = 1'b0;

    logic            err, err_pulse, y_rise_hit, y_fall_hit, cov_complete;
    logic [W-1:0]    err_count, sample_count;
    logic [7:0]      bin_hit;
    logic [8*W-1:0]  bin_count;

    logic            s_err, s_err_pulse, s_rise, s_fall, s_cov;
    logic [WS-1:0]   s_err_count, s_sample_count;
    logic [7:0]      s_bin_hit;
    logic [8*WS-1:0] s_bin_count;

    always #5 clk = ~clk;

    mux2x1_monitor #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .sel(sel), .y(y),
        .err(err), .err_pulse(err_pulse), .err_count(err_count),
        .sample_count(sample_count), .bin_hit(bin_hit), .bin_count(bin_count),
        .y_rise_hit(y_rise_hit), .y_fall_hit(y_fall_hit),
        .cov_complete(cov_complete)
    );

    mux2x1_monitor #(.CNT_W(WS)) dut_small (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .sel(sel), .y(y),
        .err(s_err), .err_pulse(s_err_pulse), .err_count(s_err_count),
        .sample_count(s_sample_count), .bin_hit(s_bin_hit),
        .bin_count(s_bin_count), .y_rise_hit(s_rise), .y_fall_hit(s_fall),
        .cov_complete(s_cov)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state of the monitor
    logic   m_exp, m_yprev, m_err, m_rise, m_fall;
    int     m_err_count, m_samples;
    int     m_bins[8];
    logic [7:0] m_hit;

    typedef struct {
        logic       pulse;
        logic       err;
        int         err_count;
        int         samples;
        logic [7:0] hit;
        logic       rise;
        logic       fall;
    } rec_t;

    rec_t q[$];

    function automatic int sat(input int v, input int w);
        int top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic model_reset();
        m_exp = 1'b0; m_yprev = 1'b0; m_err = 1'b0;
        m_rise = 1'b0; m_fall = 1'b0;
        m_err_count = 0; m_samples = 0; m_hit = '0;
        for (int n = 0; n < 8; n++) m_bins[n] = 0;
    endtask

    // Apply one vector: y shows the mux result of the previous vector
    // (inverted when bad=1), then the new inputs are presented for the edge.
    task automatic step(input logic s, input logic v1, input logic v0,
                        input logic bad);
        rec_t r;
        rec_t got;
        logic [2:0] idx;
        @(negedge clk);
        y   = m_exp ^ bad;
        sel = s; i1 = v1; i0 = v0;
        idx = {s, v1, v0};
        r.pulse = (y != m_exp);
        if (r.pulse) begin
            m_err = 1'b1;
            m_err_count++;
        end
        m_samples++;
        m_hit[idx] = 1'b1;
        m_bins[idx]++;
        if (!m_yprev && y) m_rise = 1'b1;
        if (m_yprev && !y) m_fall = 1'b1;
        m_yprev = y;
        m_exp   = s ? v1 : v0;
        r.err = m_err; r.err_count = m_err_count; r.samples = m_samples;
        r.hit = m_hit; r.rise = m_rise; r.fall = m_fall;
        q.push_back(r);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
        end else begin
            got = q.pop_front();
            check("err_pulse", err_pulse, got.pulse);
            check("err", err, got.err);
            check("err_count", err_count, sat(got.err_count, W));
            check("sample_count", sample_count, sat(got.samples, W));
            check("bin_hit", bin_hit, got.hit);
            check("y_rise_hit", y_rise_hit, got.rise);
            check("y_fall_hit", y_fall_hit, got.fall);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_err"}, err, 0);
        check({tag, "_err_pulse"}, err_pulse, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_sample_count"}, sample_count, 0);
        check({tag, "_bin_hit"}, bin_hit, 0);
        check({tag, "_bin_count"}, (bin_count == '0), 1);
        check({tag, "_rise_fall"}, {y_rise_hit, y_fall_hit}, 0);
        check({tag, "_cov"}, cov_complete, 0);
        check({tag, "_small_samples"}, s_sample_count, 0);
    endtask

    // Mid-run reset pulse of 3 ns placed away from both clock edges.
    task automatic pulse_rst(input string tag);
        @(posedge clk);
        #1 rst = 1'b1;
        y = 1'b0;
        #1 check_cleared(tag);
        model_reset();
        q.delete();
        #2 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #3 check_cleared("in_reset");
        #6 rst = 1'b0;

        // First edge after release with all inputs 0
        step(0, 0, 0, 0);
        check("first_samples", sample_count, 1);
        check("first_bin_hit", bin_hit, 8'b0000_0001);

        // All eight combinations on consecutive edges, correct mux
        for (int p = 0; p < 8; p++) begin
            logic [2:0] pv;
            pv = 3'(p);
            step(pv[2], pv[1], pv[0], 0);
        end
        step(0, 0, 0, 0);
        check("all_bins", bin_hit, 8'hFF);
        check("no_errors", err_count, 0);
        for (int n = 1; n < 8; n++)
            check($sformatf("bin%0d_count", n), bin_count[n*W +: W], 1);
        check("bin0_count", bin_count[0 +: W], m_bins[0]);
        check("cov_complete", cov_complete, 1);

        // Single faulty y with sel=0, i0=1
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        check("fault_pulse", err_pulse, 1);
        step(0, 0, 1, 0);
        check("fault_pulse_cleared", err_pulse, 0);
        check("fault_sticky", err, 1);
        check("fault_count", err_count, 1);

        // Back-to-back faults
        step(1, 1, 0, 1);
        step(1, 0, 1, 1);
        check("b2b_count", err_count, 3);
        step(0, 1, 0, 0);

        // Asynchronous clear mid-run, counting restarts from 0
        pulse_rst("midrun");
        step(1, 0, 1, 0);
        check("restart_samples", sample_count, 1);
        check("restart_bin_hit", bin_hit, 8'b0010_0000);
        step(0, 0, 0, 0);

        // y=1 at the first post-reset edge must be flagged
        pulse_rst("rv");
        step(0, 0, 0, 1);
        check("reset_value_err", err_count, 1);
        check("reset_value_pulse", err_pulse, 1);

        // Saturation of the 2-bit instance: bin 6 hit five times
        pulse_rst("sat");
        for (int k = 0; k < 5; k++) step(1, 1, 0, 0);
        check("small_bin6_sat", s_bin_count[6*WS +: WS], 3);
        check("small_samples_sat", s_sample_count, 3);
        check("small_no_err", s_err_count, 0);
        check("wide_bin6", bin_count[6*W +: W], 5);
        check("wide_samples", sample_count, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux2x1_monitor.md
# mux2x1_monitor

Synthesizable protocol checker and functional-coverage collector for the registered 2:1 multiplexer. It sits beside the mux in the test harness, taps all mux pins passively, and predicts the registered output cycle by cycle. It flags and counts mismatches, and reports which input combinations and output transitions have been exercised.

## Interface
Parameters:
- CNT_W, default 16: width of every counter (error, sample, per-bin counts).

Ports:
- clk  in  1  single clock for all monitor state; shared with the mux.
- rst  in  1  reset, asynchronous and active-high; same net as the mux reset.
- i0  in  1  mux data input 0 (observed).
- i1  in  1  mux data input 1 (observed).
- sel  in  1  mux select (observed): 0 selects i0, 1 selects i1.
- y  in  1  mux registered output (observed).
- err  out  1  sticky error flag; set on the first mismatch and held until rst.
- err_pulse  out  1  high for exactly one cycle after each mismatching edge.
- err_count  out  CNT_W  number of mismatches; saturates at all-ones.
- sample_count  out  CNT_W  number of sampled edges with rst low; saturates.
- bin_hit  out  8  bit n is set once input combination n = {sel,i1,i0} has been sampled.
- bin_count  out  8*CNT_W  per-bin saturating hit counts; bin n occupies bits [n*CNT_W +: CNT_W].
- y_rise_hit  out  1  set once a 0->1 transition of y has been observed.
- y_fall_hit  out  1  set once a 1->0 transition of y has been observed.
- cov_complete  out  1  combinational AND of all bin_hit bits, y_rise_hit and y_fall_hit.

## Operation
- Reference model of the mux:
  - The mux output y is 0 while rst is high.
  - Otherwise, on each posedge, y <= sel ? i1 : i0.
- Prediction register exp_y:
  - Async reset to 0.
  - On each posedge with rst low, loads sel ? i1 : i0.
- Check: on each posedge with rst low, compare the current (pre-edge) y against exp_y.
  - On mismatch, set err, assert err_pulse for the next cycle, and increment err_count.
- Reset-value check:
  - At the first posedge after rst deasserts, exp_y is 0, so y must be 0.
  - A nonzero y at that edge is a mismatch.
- Coverage sampling, on each posedge with rst low:
  - Increment sample_count.
  - Set bin_hit[{sel,i1,i0}] and increment that bin's count.
- y transition tracking:
  - y_prev is a register reset to 0 that samples y at each posedge with rst low.
  - y_rise_hit is set when y_prev=0 and y=1; y_fall_hit is set when y_prev=1 and y=0.
- rst high, asynchronously:
  - Clears err, err_pulse, all counters, bin_hit, y_rise_hit, y_fall_hit, exp_y and y_prev.
  - Checking and sampling are disabled while rst is high.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- All outputs are registered except cov_complete, which is combinational from registers.
- Check latency: inputs sampled at edge k are checked against y at edge k+1. err and err_count update at edge k+1; err_pulse is high during cycle k+1 to k+2.
- Every output is 0 from rst assertion until the first posedge after rst release.
- rst asserted mid-run:
  - Immediately clears all outputs.
  - Any mismatch pending at that moment is discarded.
  - The first post-release edge compares y against 0.
- Inputs changing between edges have no effect; only posedge values are used.
- Back-to-back mismatches give err_pulse high on consecutive cycles, with err_count incremented every cycle.

## Test plan
- Reset release, 10 ns clock, rst high 0-9 ns, all inputs 0:
  - err=0, err_count=0 and sample_count=0 while rst is high.
  - After the first edge, sample_count=1 and bin_hit=8'b0000_0001.
- Correct mux, all 8 {sel,i1,i0} patterns driven once each on consecutive edges:
  - bin_hit=8'hFF, every bin count=1, err_count=0.
  - Once y has toggled both ways, cov_complete=1.
- Faulty y (y driven as the inverse of the correct value for one edge, with sel=0, i0=1):
  - err_pulse is high for exactly one cycle, err=1 sticky, err_count=1.
- y forced to 1 at the first post-reset edge: a mismatch is flagged (reset-value check), err_count=1.
- rst pulsed high for 3 ns mid-run after errors have been logged:
  - All outputs clear asynchronously, without waiting for a clock edge.
  - Counting resumes from 0 after release.
- CNT_W=2, same bin hit 5 times: that bin's count is 3 (saturated) and sample_count is 3.
